// File: rtl/raster_job_sequencer.sv
// Render-job sequencer: on each new-frame indication it clears the selected
// back buffer to the background colour, starts the rasterizer, and holds
// raster-in-progress high until the rasterizer reports completion.
module raster_job_sequencer #(
   parameter int unsigned         H_RES       = 160,
   parameter int unsigned         V_RES       = 120,
   parameter int unsigned         PIXEL_W     = 8,
   parameter logic [PIXEL_W-1:0]  CLEAR_COLOR = '0,
   localparam int unsigned        ADDR_W      = $clog2(H_RES * V_RES)
) (
   input  logic               i_clk,
   input  logic               i_arst_n,
   input  logic               i_new_frame,
   input  logic               i_rasterization_target,
   input  logic               i_clear_enable,
   output logic               o_raster_in_progress,
   output logic               o_target_buffer,
   output logic               o_wr_valid,
   input  logic               i_wr_ready,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic [PIXEL_W-1:0] o_wr_data,
   output logic               o_raster_start,
   input  logic               i_raster_done,
   output logic [15:0]        o_frames_done
);

   localparam int unsigned       PIXELS    = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      CLEAR     = 4'b0010,
      START     = 4'b0100,
      WAIT_DONE = 4'b1000
   } state_t;

   state_t state;
   logic   armed;

   // Clear data never varies; the address alone identifies each write.
   assign o_wr_data = CLEAR_COLOR;

   // Job FSM with registered outputs; armed blocks re-triggering on a held new-frame level.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state                <= IDLE;
         armed                <= 1'b1;
         o_raster_in_progress <= 1'b0;
         o_target_buffer      <= 1'b0;
         o_wr_valid           <= 1'b0;
         o_wr_addr            <= '0;
         o_raster_start       <= 1'b0;
         o_frames_done        <= '0;
      end else begin
         // A low new-frame level re-arms in every state.
         if (!i_new_frame) begin
            armed <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (i_new_frame && armed) begin
                  o_target_buffer      <= i_rasterization_target;
                  armed                <= 1'b0;
                  o_raster_in_progress <= 1'b1;
                  if (i_clear_enable) begin
                     o_wr_valid <= 1'b1;
                     o_wr_addr  <= '0;
                     state      <= CLEAR;
                  end else begin
                     o_raster_start <= 1'b1;
                     state          <= START;
                  end
               end
            end

            CLEAR: begin
               // Address advances only on an accepted write, so stalls hold it.
               if (o_wr_valid && i_wr_ready) begin
                  if (o_wr_addr == LAST_ADDR) begin
                     o_wr_valid     <= 1'b0;
                     o_wr_addr      <= '0;
                     o_raster_start <= 1'b1;
                     state          <= START;
                  end else begin
                     o_wr_addr <= o_wr_addr + ADDR_W'(1);
                  end
               end
            end

            START: begin
               // Start pulse lasts exactly this one cycle; done is not looked at here.
               o_raster_start <= 1'b0;
               state          <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (i_raster_done) begin
                  o_raster_in_progress <= 1'b0;
                  o_frames_done        <= o_frames_done + 16'd1;
                  state                <= IDLE;
               end
            end

            default: begin
               o_raster_in_progress <= 1'b0;
               o_wr_valid           <= 1'b0;
               o_wr_addr            <= '0;
               o_raster_start       <= 1'b0;
               state                <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_raster_job_sequencer.sv
// Directed bench for raster_job_sequencer on a 4x2 frame with clear colour A5.
module tb_raster_job_sequencer;

   localparam logic [7:0] A5 = 8'hA5;

   logic        clk;
   logic        rst_n;
   logic        nf;
   logic        rt;
   logic        cl;
   logic        rdy;
   logic        dn;
   logic        ip;
   logic        tg;
   logic        wv;
   logic [2:0]  wa;
   logic [7:0]  wd;
   logic        rs;
   logic [15:0] fd;

   int tests;
   int fails;

   raster_job_sequencer #(
      .H_RES       (4),
      .V_RES       (2),
      .PIXEL_W     (8),
      .CLEAR_COLOR (8'hA5)
   ) dut (
      .i_clk                  (clk),
      .i_arst_n               (rst_n),
      .i_new_frame            (nf),
      .i_rasterization_target (rt),
      .i_clear_enable         (cl),
      .o_raster_in_progress   (ip),
      .o_target_buffer        (tg),
      .o_wr_valid             (wv),
      .i_wr_ready             (rdy),
      .o_wr_addr              (wa),
      .o_wr_data              (wd),
      .o_raster_start         (rs),
      .i_raster_done          (dn),
      .o_frames_done          (fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       nf;
      logic       rt;
      logic       cl;
      logic       rdy;
      logic       dn;
      logic       ip;
      logic       tg;
      logic       wv;
      logic [2:0] wa;
      logic       rs;
      int         fd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic a_nf, logic a_rt, logic a_cl, logic a_rdy, logic a_dn,
                               logic e_ip, logic e_tg, logic e_wv, int e_wa, logic e_rs, int e_fd);
      vec_t v;
      v.nf = a_nf; v.rt = a_rt; v.cl = a_cl; v.rdy = a_rdy; v.dn = a_dn;
      v.ip = e_ip; v.tg = e_tg; v.wv = e_wv; v.wa = 3'(e_wa); v.rs = e_rs; v.fd = e_fd;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input int e_ip, input int e_tg, input int e_wv,
                           input int e_wa, input int e_rs, input int e_fd);
      chk({tag, "_in_progress"}, int'(ip), e_ip);
      chk({tag, "_target"},      int'(tg), e_tg);
      chk({tag, "_wr_valid"},    int'(wv), e_wv);
      chk({tag, "_wr_addr"},     int'(wa), e_wa);
      chk({tag, "_start"},       int'(rs), e_rs);
      chk({tag, "_frames"},      int'(fd), e_fd);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      nf = 1'b0; rt = 1'b0; cl = 1'b1; rdy = 1'b1; dn = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int acc_addr[$];
      int starts;
      logic pv, pr;
      logic [2:0] pa;
      logic back;
      int exp_tg[3];

      tests = 0;
      fails = 0;

      // Job start, full clear with done during clear and at the start pulse,
      // held new-frame level, no-clear job, target changes after start.
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,0,0,0));
      vecs.push_back(mk(1,0,1,1,1, 1,0,1,1,0,0));
      vecs.push_back(mk(1,1,1,1,0, 1,0,1,2,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,3,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,4,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,5,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,6,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,1,7,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,0,0,1,0));
      vecs.push_back(mk(1,0,1,1,1, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,1,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,1,1,1, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,1,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,1,0,1,0, 1,1,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,1, 1,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1, 0,1,0,0,0,2));
      vecs.push_back(mk(0,0,0,1,0, 0,1,0,0,0,2));

      // Reset state with new-frame already high.
      rst_n = 1'b0;
      nf = 1'b1; rt = 1'b0; cl = 1'b1; rdy = 1'b1; dn = 1'b0;
      repeat (2) tick();
      chk_outs("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         nf = vecs[i].nf; rt = vecs[i].rt; cl = vecs[i].cl; rdy = vecs[i].rdy; dn = vecs[i].dn;
         tick();
         chk_outs($sformatf("vec%0d", i), int'(vecs[i].ip), int'(vecs[i].tg), int'(vecs[i].wv),
                  int'(vecs[i].wa), int'(vecs[i].rs), vecs[i].fd);
         if (wv) chk($sformatf("vec%0d_wr_data", i), int'(wd), int'(A5));
      end

      // Clear with a 1,0,0 ready pattern: held address across stalls, no gaps or repeats.
      nf = 1'b1; rt = 1'b0; cl = 1'b1; rdy = 1'b0; dn = 1'b0;
      tick();
      chk("stall_job_start_valid", int'(wv), 1);
      chk("stall_job_start_addr", int'(wa), 0);
      starts = 0;
      for (int i = 0; i < 30; i++) begin
         rdy = ((i % 3) == 0);
         pv = wv; pr = rdy; pa = wa;
         if (wv && rdy) acc_addr.push_back(int'(wa));
         tick();
         if (pv && !pr) begin
            chk("stall_addr_hold", int'(wa), int'(pa));
            chk("stall_valid_hold", int'(wv), 1);
         end
         if (rs) starts++;
      end
      chk("stall_write_count", acc_addr.size(), 8);
      foreach (acc_addr[k]) chk($sformatf("stall_addr_order%0d", k), acc_addr[k], k);
      chk("stall_start_pulses", starts, 1);
      chk("stall_wait_in_progress", int'(ip), 1);
      dn = 1'b1; nf = 1'b0;
      tick();
      dn = 1'b0;
      chk("stall_done_in_progress", int'(ip), 0);
      chk("stall_done_frames", int'(fd), 3);

      // Reset asserted mid-clear at address 3 with target 1, then restart from 0.
      rt = 1'b1; nf = 1'b1; cl = 1'b1; rdy = 1'b1;
      tick();
      chk("abort_target", int'(tg), 1);
      for (int k = 0; k < 10 && wa != 3'd3; k++) tick();
      chk("abort_reach_addr3", int'(wa), 3);
      #2 rst_n = 1'b0;
      #1;
      chk_outs("abort", 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      tick();
      chk_outs("restart", 1, 1, 1, 0, 0, 0);
      tick();
      chk("restart_next_addr", int'(wa), 1);

      // Closed loop with a swapping controller that swaps after every job.
      do_reset();
      exp_tg[0] = 0; exp_tg[1] = 1; exp_tg[2] = 0;
      back = 1'b0;
      for (int j = 0; j < 3; j++) begin
         rt = back; nf = 1'b1; cl = 1'b1; rdy = 1'b1; dn = 1'b0;
         for (int k = 0; k < 20 && !ip; k++) tick();
         chk($sformatf("loop%0d_started", j), int'(ip), 1);
         chk($sformatf("loop%0d_target", j), int'(tg), exp_tg[j]);
         nf = 1'b0;
         for (int k = 0; k < 40 && !rs; k++) tick();
         chk($sformatf("loop%0d_start_seen", j), int'(rs), 1);
         tick();
         dn = 1'b1;
         tick();
         dn = 1'b0;
         chk($sformatf("loop%0d_ended", j), int'(ip), 0);
         chk($sformatf("loop%0d_frames", j), int'(fd), j + 1);
         back = ~back;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
